// File: rtl/leaf_acc_pkg.sv
// Shared types, widths and the saturating clamp for the multi-core leaf accumulator.
// Leaf-value and class-id widths are codebase-wide constants, so they live here.
package leaf_acc_pkg;

    localparam int unsigned LEAF_VALUES_NUM_BITS = 8;
    localparam int unsigned CLASS_ID_NUM_BITS    = 3;
    localparam int unsigned ACC_MAX_WIDTH        = 64;

    typedef enum logic [1:0] {
        START,
        ACCUM,
        OUTPUT
    } leaf_acc_state_t;

    // Widest signed accumulator word; per-instance accumulators are truncated views of it.
    typedef logic signed [ACC_MAX_WIDTH-1:0] leaf_acc_word_t;

    function automatic leaf_acc_word_t sat_clamp(input leaf_acc_word_t wide,
                                                 input int unsigned    acc_width);
        leaf_acc_word_t hi;
        leaf_acc_word_t lo;
        hi = (leaf_acc_word_t'(1) <<< (acc_width - 1)) - leaf_acc_word_t'(1);
        lo = -hi - leaf_acc_word_t'(1);
        if (wide > hi) begin
            return hi;
        end else if (wide < lo) begin
            return lo;
        end
        return wide;
    endfunction

endpackage

// File: rtl/leaf_class_adder.sv
// Combinational per-class adder: sums the accepted leaf values of all cores into each class lane
// and flags any accepted beat whose class id has no lane.
module leaf_class_adder
    import leaf_acc_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned SUM_W       = LEAF_VALUES_NUM_BITS + 3
) (
    input  logic [NUM_CORES-1:0]                           accepted,
    input  logic [NUM_CORES-1:0][LEAF_VALUES_NUM_BITS-1:0] leaf_values,
    input  logic [NUM_CORES-1:0][CLASS_ID_NUM_BITS-1:0]    class_ids,
    output logic [NUM_CLASSES-1:0][SUM_W-1:0]              class_sums,
    output logic                                           bad_class
);

    always_comb begin
        class_sums = '0;
        bad_class  = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (accepted[i]) begin
                if (32'(class_ids[i]) >= NUM_CLASSES) begin
                    bad_class = 1'b1;
                end
                for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                    if (32'(class_ids[i]) == c) begin
                        class_sums[c] = class_sums[c] + SUM_W'($signed(leaf_values[i]));
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_core_leaf_accumulator.sv
// Collects per-core leaf-value beats, sums them into saturating per-class accumulators and
// emits one result vector per query once every enabled core has sent its last beat.
module multi_core_leaf_accumulator
    import leaf_acc_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned ACC_WIDTH   = LEAF_VALUES_NUM_BITS + 8,
    parameter int unsigned QID_WIDTH   = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_CORES-1:0]                           core_enable,
    input  logic [NUM_CORES-1:0]                           s_valid,
    output logic [NUM_CORES-1:0]                           s_ready,
    input  logic [NUM_CORES-1:0]                           s_last,
    input  logic [NUM_CORES-1:0][LEAF_VALUES_NUM_BITS-1:0] s_leaf_values,
    input  logic [NUM_CORES-1:0][CLASS_ID_NUM_BITS-1:0]    s_class_ids,
    output logic                                           m_valid,
    input  logic                                           m_ready,
    output logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0]          m_class_sums,
    output logic [QID_WIDTH-1:0]                           m_query_id,
    output logic                                           m_overflow,
    output logic                                           m_bad_class
);

    localparam int unsigned PART_W = LEAF_VALUES_NUM_BITS + $clog2(NUM_CORES + 1);
    localparam int unsigned WIDE_W = ACC_WIDTH + $clog2(NUM_CORES + 1);

    leaf_acc_state_t                      state_q;
    leaf_acc_state_t                      state_d;
    logic [NUM_CORES-1:0]                 en_q;
    logic [NUM_CORES-1:0]                 done_q;
    logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0] acc_q;
    logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0] acc_d;
    logic                                 ovf_q;
    logic                                 bad_q;
    logic [QID_WIDTH-1:0]                 qid_q;

    logic [NUM_CORES-1:0]                 accepted;
    logic [NUM_CORES-1:0]                 last_hit;
    logic                                 all_done;
    logic [NUM_CLASSES-1:0][PART_W-1:0]   partial;
    logic                                 bad_hit;
    logic                                 ovf_hit;
    logic signed [WIDE_W-1:0]             wide;
    leaf_acc_word_t                       clamped;

    always_comb begin
        s_ready = '0;
        if (state_q == ACCUM) begin
            s_ready = en_q & ~done_q;
        end
    end

    assign accepted = s_valid & s_ready;
    assign last_hit = accepted & s_last;
    // Cores finishing in this very cycle count as done so their final beats share the exit cycle.
    assign all_done = ((done_q | last_hit) & en_q) == en_q;

    leaf_class_adder #(
        .NUM_CORES   (NUM_CORES),
        .NUM_CLASSES (NUM_CLASSES),
        .SUM_W       (PART_W)
    ) u_class_adder (
        .accepted    (accepted),
        .leaf_values (s_leaf_values),
        .class_ids   (s_class_ids),
        .class_sums  (partial),
        .bad_class   (bad_hit)
    );

    always_comb begin
        acc_d   = acc_q;
        ovf_hit = 1'b0;
        wide    = '0;
        clamped = '0;
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            wide     = WIDE_W'($signed(acc_q[c])) + WIDE_W'($signed(partial[c]));
            clamped  = sat_clamp(leaf_acc_word_t'(wide), ACC_WIDTH);
            acc_d[c] = clamped[ACC_WIDTH-1:0];
            if (clamped != leaf_acc_word_t'(wide)) begin
                ovf_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            START:   if (core_enable != '0) state_d = ACCUM;
            ACCUM:   if (all_done)          state_d = OUTPUT;
            OUTPUT:  if (m_ready)           state_d = START;
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= START;
            en_q    <= '0;
            done_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
            qid_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                START: begin
                    en_q   <= core_enable;
                    done_q <= '0;
                    acc_q  <= '0;
                    ovf_q  <= 1'b0;
                    bad_q  <= 1'b0;
                end
                ACCUM: begin
                    acc_q  <= acc_d;
                    done_q <= done_q | last_hit;
                    ovf_q  <= ovf_q | ovf_hit;
                    bad_q  <= bad_q | bad_hit;
                end
                OUTPUT: begin
                    if (m_ready) begin
                        qid_q <= qid_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid      = (state_q == OUTPUT);
    assign m_class_sums = acc_q;
    assign m_query_id   = qid_q;
    assign m_overflow   = ovf_q;
    assign m_bad_class  = bad_q;

endmodule

// File: tb/tb_multi_core_leaf_accumulator.sv
// Randomized and directed checks of the leaf accumulator against a per-cycle arithmetic model.
module tb_multi_core_leaf_accumulator;
    import leaf_acc_pkg::*;

    localparam int unsigned NC = 3;
    localparam int unsigned NK = 4;
    localparam int unsigned LW = LEAF_VALUES_NUM_BITS;
    localparam int unsigned CW = CLASS_ID_NUM_BITS;
    localparam int unsigned AW = LEAF_VALUES_NUM_BITS + 2;
    localparam int unsigned QW = 8;
    localparam longint ACC_HI = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint ACC_LO = -ACC_HI - 1;

    logic                       clk;
    logic                       rst;
    logic [NC-1:0]              core_enable;
    logic [NC-1:0]              s_valid;
    logic [NC-1:0]              s_ready;
    logic [NC-1:0]              s_last;
    logic [NC-1:0][LW-1:0]      s_leaf_values;
    logic [NC-1:0][CW-1:0]      s_class_ids;
    logic                       m_valid;
    logic                       m_ready;
    logic [NK-1:0][AW-1:0]      m_class_sums;
    logic [QW-1:0]              m_query_id;
    logic                       m_overflow;
    logic                       m_bad_class;

    multi_core_leaf_accumulator #(
        .NUM_CORES   (NC),
        .NUM_CLASSES (NK),
        .ACC_WIDTH   (AW),
        .QID_WIDTH   (QW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_enable   (core_enable),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_last        (s_last),
        .s_leaf_values (s_leaf_values),
        .s_class_ids   (s_class_ids),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_class_sums  (m_class_sums),
        .m_query_id    (m_query_id),
        .m_overflow    (m_overflow),
        .m_bad_class   (m_bad_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          val;
        int unsigned cls;
        bit          last;
    } beat_t;

    beat_t         beats [NC][16];
    int unsigned   nb [NC];
    int unsigned   hd [NC];
    longint        exp_acc [NK];
    bit            exp_ovf;
    bit            exp_bad;
    logic [QW-1:0] exp_qid;
    int unsigned   n_checks;
    int unsigned   n_errs;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic clear_beats();
        for (int i = 0; i < NC; i++) begin
            nb[i] = 0;
            hd[i] = 0;
        end
    endtask

    task automatic add_beat(input int unsigned core, input int val, input int unsigned cls, input bit last);
        beats[core][nb[core]].val  = val;
        beats[core][nb[core]].cls  = cls;
        beats[core][nb[core]].last = last;
        nb[core]++;
    endtask

    task automatic idle_cycles(input int unsigned n);
        core_enable = '0;
        s_valid     = '0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_s_ready", longint'(s_ready), 0);
            check("idle_m_valid", longint'(m_valid), 0);
        end
    endtask

    // Entered while the DUT sits in START before the edge that samples core_enable.
    task automatic run_query(input logic [NC-1:0] en, input bit gaps, input int unsigned hold);
        logic [NC-1:0] done_m;
        logic [NC-1:0] vld;
        logic [NC-1:0] acc_m;
        longint        lane_sum [NK];
        int unsigned   cyc;
        bit            fin;

        core_enable = en;
        s_valid     = '0;
        m_ready     = 1'b0;
        @(posedge clk);
        #1;
        core_enable = NC'($urandom);
        for (int c = 0; c < NK; c++) exp_acc[c] = 0;
        exp_ovf = 1'b0;
        exp_bad = 1'b0;
        done_m  = '0;
        fin     = 1'b0;
        cyc     = 0;
        while (!fin) begin
            for (int i = 0; i < NC; i++) begin
                if (en[i] && !done_m[i] && hd[i] < nb[i]) begin
                    vld[i]           = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                    s_leaf_values[i] = LW'(beats[i][hd[i]].val);
                    s_class_ids[i]   = CW'(beats[i][hd[i]].cls);
                    s_last[i]        = beats[i][hd[i]].last;
                end else begin
                    vld[i]           = 1'b1;
                    s_leaf_values[i] = LW'($urandom);
                    s_class_ids[i]   = CW'($urandom);
                    s_last[i]        = 1'($urandom);
                end
            end
            s_valid = vld;
            @(negedge clk);
            check("s_ready", longint'(s_ready), longint'(en & ~done_m));
            check("m_valid_low", longint'(m_valid), 0);
            acc_m = vld & en & ~done_m;
            for (int c = 0; c < NK; c++) lane_sum[c] = 0;
            for (int i = 0; i < NC; i++) begin
                if (acc_m[i]) begin
                    if (beats[i][hd[i]].cls >= NK) exp_bad = 1'b1;
                    else lane_sum[beats[i][hd[i]].cls] += beats[i][hd[i]].val;
                    if (beats[i][hd[i]].last) done_m[i] = 1'b1;
                    hd[i]++;
                end
            end
            for (int c = 0; c < NK; c++) begin
                exp_acc[c] += lane_sum[c];
                if (exp_acc[c] > ACC_HI) begin
                    exp_acc[c] = ACC_HI;
                    exp_ovf    = 1'b1;
                end else if (exp_acc[c] < ACC_LO) begin
                    exp_acc[c] = ACC_LO;
                    exp_ovf    = 1'b1;
                end
            end
            if ((done_m & en) == en) fin = 1'b1;
            cyc++;
            if (!fin && cyc >= 200) begin
                check("accum_timeout", 1, 0);
                fin = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = '0;
        for (int unsigned k = 0; k <= hold; k++) begin
            m_ready = (k == hold);
            @(negedge clk);
            check("m_valid", longint'(m_valid), 1);
            check("m_query_id", longint'(m_query_id), longint'(exp_qid));
            check("m_overflow", longint'(m_overflow), longint'(exp_ovf));
            check("m_bad_class", longint'(m_bad_class), longint'(exp_bad));
            check("out_s_ready", longint'(s_ready), 0);
            for (int c = 0; c < NK; c++) begin
                check($sformatf("sum%0d", c), longint'($signed(m_class_sums[c])), exp_acc[c]);
            end
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        exp_qid = exp_qid + 1'b1;
        @(negedge clk);
        check("start_m_valid", longint'(m_valid), 0);
        check("start_s_ready", longint'(s_ready), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NC-1:0] en;
        int unsigned   n;

        n_checks      = 0;
        n_errs        = 0;
        exp_qid       = '0;
        rst           = 1'b0;
        core_enable   = '0;
        s_valid       = '0;
        s_last        = '0;
        s_leaf_values = '0;
        s_class_ids   = '0;
        m_ready       = 1'b0;
        clear_beats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", longint'(m_valid), 0);
        check("rst_s_ready", longint'(s_ready), 0);
        check("rst_qid", longint'(m_query_id), 0);
        check("rst_sum0", longint'(m_class_sums), 0);
        check("rst_flags", longint'({m_overflow, m_bad_class}), 0);
        rst = 1'b1;

        // 1: single last beat per core
        clear_beats();
        add_beat(0, 5, 0, 1'b1);
        add_beat(1, -2, 0, 1'b1);
        add_beat(2, 7, 1, 1'b1);
        run_query(3'b111, 1'b0, 0);

        // 2: multi-beat core alongside single-beat cores
        clear_beats();
        add_beat(0, 4, 2, 1'b1);
        add_beat(1, 1, 2, 1'b0);
        add_beat(1, 1, 2, 1'b0);
        add_beat(1, 1, 2, 1'b1);
        add_beat(2, -3, 2, 1'b1);
        run_query(3'b111, 1'b0, 1);

        // 3: core 1 disabled, holding junk valid throughout
        clear_beats();
        add_beat(0, 9, 3, 1'b1);
        add_beat(2, -20, 3, 1'b0);
        add_beat(2, 6, 0, 1'b1);
        run_query(3'b101, 1'b0, 0);

        // 4: saturation, then a clean query
        clear_beats();
        for (int i = 0; i < NC; i++) for (int j = 0; j < 4; j++) add_beat(i, 127, 0, j == 3);
        run_query(3'b111, 1'b0, 0);
        clear_beats();
        for (int i = 0; i < NC; i++) add_beat(i, 1, 1, 1'b1);
        run_query(3'b111, 1'b0, 0);

        // 5: out-of-range class, result held for 10 cycles
        clear_beats();
        add_beat(0, 33, NK, 1'b1);
        add_beat(1, 12, 1, 1'b1);
        add_beat(2, -8, 3, 1'b1);
        run_query(3'b111, 1'b0, 10);

        // 6: reset in the middle of accumulation
        core_enable = 3'b111;
        s_valid     = '0;
        @(posedge clk);
        #1;
        s_valid          = 3'b001;
        s_leaf_values[0] = LW'(50);
        s_class_ids[0]   = '0;
        s_last[0]        = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_sum0", longint'($signed(m_class_sums[0])), 100);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_m_valid", longint'(m_valid), 0);
        check("mid_rst_sums", longint'(m_class_sums), 0);
        check("mid_rst_qid", longint'(m_query_id), 0);
        check("mid_rst_flags", longint'({m_overflow, m_bad_class}), 0);
        check("mid_rst_s_ready", longint'(s_ready), 0);
        core_enable = '0;
        s_valid     = '0;
        @(negedge clk);
        rst     = 1'b1;
        exp_qid = '0;
        clear_beats();
        add_beat(0, 10, 0, 1'b1);
        add_beat(1, -4, 0, 1'b1);
        add_beat(2, 2, 3, 1'b1);
        run_query(3'b111, 1'b0, 0);

        // Random queries; enough of them to wrap the query id.
        for (int q = 0; q < 270; q++) begin
            if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
            en = NC'($urandom_range(1, (1 << NC) - 1));
            clear_beats();
            for (int i = 0; i < NC; i++) begin
                if (en[i]) begin
                    n = $urandom_range(1, 4);
                    for (int j = 0; j < int'(n); j++) begin
                        add_beat(i, int'($urandom_range(0, 255)) - 128,
                                 ($urandom_range(0, 7) == 0) ? $urandom_range(NK, (1 << CW) - 1)
                                                             : $urandom_range(0, NK - 1),
                                 j == int'(n) - 1);
                    end
                end
            end
            run_query(en, 1'b1, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
